muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its own sequencer and HI/LO result registers.
- Sits beside the ALU.
- The control unit raises `start` with an opcode and operands, stalls on `busy`, and reads HI/LO after `done`, steering them into register writeback.
- Shift-add multiply, restoring divide; one iteration per clock.

Parameters:
WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH

Ports:
clock      input   1      system clock, rising edge
reset      input   1      asynchronous, active-low; 0 clears all state immediately
start      input   1      request; sampled only in IDLE
op         input   2      0=MULT 1=MULTU 2=DIV 3=DIVU; sampled with start
a          input   WIDTH  multiplicand / dividend; sampled with start
b          input   WIDTH  multiplier / divisor; sampled with start
abort      input   1      synchronous cancel of an in-flight operation
busy       output  1      1 in RUN and FINISH
done       output  1      one-cycle pulse; HI/LO are valid in the same cycle
div_zero   output  1      one-cycle pulse together with done when a DIV/DIVU divisor is 0
hi         output  WIDTH  HI register (product upper half / remainder)
lo         output  WIDTH  LO register (product lower half / quotient)
state_out  output  2      0=IDLE 1=RUN 2=FINISH (debug)

Behaviour:
- Reset (reset=0), asynchronous:
  - state=IDLE; hi=0, lo=0; busy=0, done=0, div_zero=0.
  - Internal accumulator and counter cleared.
  - A reset mid-operation discards the operation; no done is generated.
- IDLE:
  - On start=1 and abort=0: latch op, a, b; counter=0.
  - If op is DIV/DIVU and b==0: go to FINISH with the zero flag set. Otherwise go to RUN.
  - start and abort high together: abort wins; stay IDLE.
- RUN, one iteration per edge, counter++:
  - Multiply: if multiplier bit0 is 1, add multiplicand into the upper half of the 2*WIDTH product register; then shift right 1, with the adder carry entering the MSB.
  - Divide: shift {rem, quo} left 1; trial = rem - divisor. If trial >= 0 (no borrow), rem = trial and quo bit0 = 1.
  - When counter reaches WIDTH-1 on an edge, the next state is FINISH.
- FINISH, one cycle:
  - On the exiting edge, load hi/lo: product {upper, lower} for multiply; {rem, quo} for divide.
  - On a zero divisor, hi/lo are left unchanged.
  - Register done=1 (and div_zero=1 if the zero flag is set) for exactly the following cycle; return to IDLE.
- Latency:
  - Normal operation: done is high in the cycle after the (WIDTH+1)th edge following the start-sampling edge (34 edges for WIDTH=32).
  - Zero divisor: done after 2 edges.
- busy:
  - Combinational from state, so it is 1 in the cycle after start is sampled.
  - It is 0 in the done cycle, and a new start is accepted in that cycle.
- start while busy: ignored, with no queuing.
- abort in RUN or FINISH:
  - Next edge returns to IDLE; hi/lo unchanged; done and div_zero stay 0.
  - If abort coincides with the FINISH exit edge, abort wins.
- Arithmetic: all operations are modulo 2^WIDTH; there are no overflow flags.

Optional Feature:
MULDIV_SIGNED_EN
- Defined:
  - MULT/DIV convert operands to magnitudes at start and record the sign bits.
  - FINISH negates the results as follows:
    - product when the operand signs differ;
    - quotient when the signs differ;
    - remainder when the dividend is negative.
  - The negation is two's-complement, applied in the same cycle before hi/lo load.
  - -2^(WIDTH-1) / -1 yields lo=0x80000000, hi=0.
- Undefined: MULT behaves identically to MULTU, and DIV to DIVU. The sign logic is not synthesised.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum muldiv_op_t {MULT, MULTU, DIV, DIVU};
  - typedef enum muldiv_state_t {IDLE, RUN, FINISH};
  - localparam state encodings matching state_out.
- Sub-module muldiv_step (combinational): one shift-add or restoring-divide iteration.
  - Inputs: accumulator, operand, op class.
  - Outputs: next accumulator.
  - The sequencer keeps state, counter, sign fixup and the HI/LO registers.

Test Plan:
- MULTU a=5 b=10 → done at edge 34; hi=0x00000000, lo=0x00000032; busy high for edges 1..33.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU a=100 b=7 → lo=14, hi=2; then DIV a=x b=0 with prior hi/lo → done and div_zero after 2 edges, hi/lo unchanged.
- MULT a=0xFFFFFFFD (-3) b=7:
  - with MULDIV_SIGNED_EN → hi=0xFFFFFFFF, lo=0xFFFFFFEB;
  - without → hi=0x00000006, lo=0xFFFFFFEB.
- DIV a=-7 b=2 with MULDIV_SIGNED_EN → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Cancellation cases:
  - start MULTU, abort at edge 10 → IDLE next edge, no done, hi/lo kept;
  - repeat with reset=0 at edge 10 → all outputs 0 immediately;
  - start during busy is ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types, state encodings and opcode decode for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RUN    = ST_RUN,
    FINISH = ST_FINISH
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    logic r;
    case (op)
      MULT, MULTU: r = 1'b0;
      DIV, DIVU:   r = 1'b1;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    logic r;
    case (op)
      MULT, DIV:    r = 1'b1;
      MULTU, DIVU:  r = 1'b0;
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the control unit (master) and the multiply/divide sequencer (slave).
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) ();
  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       state_out;

  modport master (
    output start, op, a, b, abort,
    input  busy, done, div_zero, hi, lo, state_out
  );

  modport slave (
    input  start, op, a, b, abort,
    output busy, done, div_zero, hi, lo, state_out
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] diff_s;

  // Remainder is below the divisor, so diff_s[WIDTH] is exactly the trial borrow.
  always_comb begin
    sum_s    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, operand_i};
    rem_sh_s = acc_i[2*WIDTH-1:WIDTH-1];
    diff_s   = rem_sh_s - {1'b0, operand_i};
    if (is_div_i) begin
      if (!diff_s[WIDTH]) begin
        acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_i[0]) begin
        acc_o = {sum_s, acc_i[WIDTH-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO result registers, one iteration per clock.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they behave as MULTU/DIVU.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clock,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = '0;

  muldiv_state_t      state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_s;
  logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, zero_q, zero_d;
  logic               done_q, done_d, div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, res_hi_s, res_lo_s;
  logic               start_div_s;
`ifdef MULDIV_SIGNED_EN
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic               start_signed_s;
  logic [2*WIDTH-1:0] prod_neg_s;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .is_div_i  (is_div_q),
    .acc_o     (step_s)
  );

  assign start_div_s = op_is_div(bus.op);

`ifdef MULDIV_SIGNED_EN
  assign start_signed_s = op_is_signed(bus.op);
  assign prod_neg_s     = {(2*WIDTH){1'b0}} - acc_q;

  // Signed ops iterate on magnitudes; the sign bits are kept for the FINISH fixup.
  always_comb begin
    if (start_signed_s && bus.a[WIDTH-1]) begin
      a_mag_s = ZERO_W - bus.a;
    end else begin
      a_mag_s = bus.a;
    end
    if (start_signed_s && bus.b[WIDTH-1]) begin
      b_mag_s = ZERO_W - bus.b;
    end else begin
      b_mag_s = bus.b;
    end
  end

  // Two's-complement result fixup applied just before HI/LO load.
  always_comb begin
    res_hi_s = acc_q[2*WIDTH-1:WIDTH];
    res_lo_s = acc_q[WIDTH-1:0];
    if (is_div_q) begin
      if (neg_rem_q) res_hi_s = ZERO_W - acc_q[2*WIDTH-1:WIDTH];
      else           res_hi_s = acc_q[2*WIDTH-1:WIDTH];
      if (neg_res_q) res_lo_s = ZERO_W - acc_q[WIDTH-1:0];
      else           res_lo_s = acc_q[WIDTH-1:0];
    end else if (neg_res_q) begin
      res_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_neg_s[WIDTH-1:0];
    end else begin
      res_hi_s = acc_q[2*WIDTH-1:WIDTH];
      res_lo_s = acc_q[WIDTH-1:0];
    end
  end
`else
  assign a_mag_s  = bus.a;
  assign b_mag_s  = bus.b;
  assign res_hi_s = acc_q[2*WIDTH-1:WIDTH];
  assign res_lo_s = acc_q[WIDTH-1:0];
`endif

  // Next-state and datapath updates; abort always returns to IDLE without a done pulse.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    zero_d     = zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          cnt_d    = '0;
          is_div_d = start_div_s;
          zero_d   = start_div_s && (bus.b == ZERO_W);
          if (start_div_s) begin
            acc_d  = {ZERO_W, a_mag_s};
            opnd_d = b_mag_s;
          end else begin
            acc_d  = {ZERO_W, b_mag_s};
            opnd_d = a_mag_s;
          end
`ifdef MULDIV_SIGNED_EN
          neg_res_d = start_signed_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d = start_signed_s && start_div_s && bus.a[WIDTH-1];
`endif
          if (start_div_s && (bus.b == ZERO_W)) state_d = FINISH;
          else                                  state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          acc_d = step_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_d = FINISH;
          else                   state_d = RUN;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (!bus.abort) begin
          done_d     = 1'b1;
          div_zero_d = zero_q;
          if (!zero_q) begin
            hi_d = res_hi_s;
            lo_d = res_lo_s;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      zero_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      zero_q     <= zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.state_out = state_q;
endmodule
